// File: rtl/mem_pkg.sv
// Shared types and constants for the backing-memory line controller.
// Line geometry, FSM state encoding and index-width helper.
package mem_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic int clog2(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_line_sram.sv
// Single-port DEPTH x W line array with registered read data.
// The read register only moves on a read access, so it holds between them.
module line_sram #(
  parameter int W     = 256,
  parameter int DEPTH = 512,
  parameter int IW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// Fixed-latency line memory behind the data cache memory port.
// One outstanding request; access happens on the last wait edge.
module mem_line_ctrl #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  import mem_pkg::*;

  localparam int IW = clog2(DEPTH);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t state;
  state_t state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic accept;
  logic access;

  logic [IW-1:0]     req_idx;
  logic              req_we;
  logic [LINE_W-1:0] req_data;
  logic [IW-1:0]     in_idx;

  logic              mem_en;
  logic              mem_we;
  logic [IW-1:0]     mem_idx;
  logic [LINE_W-1:0] mem_wdata;

  logic unused_addr;

  assign in_idx = addr_i[OFFSET_BITS +: IW];
  assign unused_addr = ^{addr_i[ADDR_W-1:OFFSET_BITS+IW],
                         addr_i[OFFSET_BITS-1:0]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_i) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_n = ACK;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= CW'(1)) begin
          access  = 1'b1;
          state_n = ACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_idx  <= in_idx;
      req_we   <= write_i;
      req_data <= data_i;
    end
  end

  // A single-cycle latency accesses straight from the live inputs.
  always_comb begin
    mem_en    = access && !rst_i;
    mem_we    = req_we;
    mem_idx   = req_idx;
    mem_wdata = req_data;
    if (state == IDLE) begin
      mem_we    = write_i;
      mem_idx   = in_idx;
      mem_wdata = data_i;
    end
  end

  line_sram #(
    .W     (LINE_W),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_sram (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (mem_en),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (data_o)
  );

  assign ack_o  = (state == ACK);
  assign busy_o = (state == WAIT);

endmodule
